glm_load: RTL and testbench
===========================

// Module: glm_load
// PURPOSE
// - DRAM->BRAM load engine; the read-direction counterpart of the GLM writeback stage.
// - On op_start, decodes the register set and computes the DRAM line address.
// - Issues one DMA read request, then streams the returned 512b lines into the selected on-chip BRAM channel.
// - Sits between the instruction dispatcher and the DMA read engine; feeds model, label and sample memories.
// PARAMETERS
// - NUM_CHANNELS  2    number of BRAM write channels (0 model, 1 labels, 2.. samples)
// - CL_ADDR_W     42   DRAM cache-line address width
// - BRAM_ADDR_W   10   BRAM line address width
// - DATA_W        512  line width
// PORTS
// - clk               in   1                  clock
// - reset             in   1                  synchronous, active-high
// - op_start          in   1                  start pulse, sampled in IDLE only
// - op_done           out  1                  one-cycle completion pulse
// - regs              in   7x32               instruction registers
// - in_addr           in   CL_ADDR_W          input buffer base
// - out_addr          in   CL_ADDR_W          output buffer base
// - dma_start         out  1                  one-cycle read request pulse
// - dma_addr          out  CL_ADDR_W          request start line
// - dma_length        out  32                 request length in lines
// - dma_active        in   1                  DMA read engine busy
// - rx_rvalid         in   1                  returned line valid; in order
// - rx_rdata          in   DATA_W             returned line
// - rx_ralmostfull    out  1                  backpressure to DMA
// - bram_we           out  NUM_CHANNELS       per-channel write enable
// - bram_waddr        out  BRAM_ADDR_W        shared write address
// - bram_wdata        out  DATA_W             shared write data
// BEHAVIOUR
// - Reset: state IDLE; op_done, dma_start, bram_we, rx_ralmostfull all 0.
//   - Reset mid-op abandons the op; no op_done.
//   - rx_rvalid arriving in IDLE is dropped.
// - Register decode, latched in IDLE on op_start:
//   - regs[0..2]: offsets.
//   - regs[3][31]: base select, 0 = in_addr, 1 = out_addr; regs[3][30:0] is added to the base.
//   - regs[4]: length in lines.
//   - regs[5][3:0]: channel.
//   - regs[6][BRAM_ADDR_W-1:0]: BRAM base.
// - IDLE -> DONE if regs[4]==0; otherwise IDLE -> PREPROCESS.
// - PREPROCESS: 3 cycles; each cycle adds one of offset[0], offset[1], offset[2] to the address
//   - Adds are modulo 2^CL_ADDR_W; offsets are zero-extended.
//   - Then -> REQUEST.
// - REQUEST: when !dma_active, pulse dma_start with dma_addr and dma_length, then -> RECEIVE.
//   - If dma_active is set, wait.
// - RECEIVE: each rx_rvalid registers a write one cycle later:
//   - bram_we[ch]=1, bram_waddr = base+count (wraps mod 2^BRAM_ADDR_W), bram_wdata = rx_rdata.
//   - count is 32b. When count==length-1 is sampled, -> DONE.
// - DONE: op_done=1 for one cycle, -> IDLE.
//   - Latency: last rx_rvalid at t -> last bram_we at t+1 -> op_done at t+2.
// - Channel >= NUM_CHANNELS: lines are consumed and counted, no bram_we bit is set, op_done still fires.
// - rx_ralmostfull=1 in every state except RECEIVE.
// - op_start outside IDLE is ignored.
// TESTING
// - in_addr=0x1000, regs3=0x5, offsets 1,2,3, len 4, ch0, base 0
//   -> dma_addr=0x100B, dma_length=4; bram_we[0] at addrs 0..3 with data in order; one op_done.
// - len=0 -> no dma_start, no bram_we; op_done 2 cycles after op_start.
// - regs3[31]=1, out_addr=0x2000, len 2, ch1, base 0x3FE
//   -> dma_addr=0x2000; writes at 0x3FE, 0x3FF; no wrap past the second line.
// - len 3, base 0x3FF -> writes at 0x3FF, 0x000, 0x001 (wrap).
// - dma_active held high 5 cycles in REQUEST -> dma_start delayed until the cycle after it drops.
// - Reset asserted after 2 of 4 lines
//   -> IDLE, no op_done; late rx_rvalid dropped; next op runs clean.
// - Channel 7 with NUM_CHANNELS=2, len 2 -> bram_we stays 0; op_done fires.

Source files
------------

// File: rtl/glm_load.sv
// glm_load: DRAM->BRAM load engine; decodes regs, issues one DMA read, streams returned lines into a BRAM channel.
// Latency: op_start -> dma_start 5 cycles later when the DMA is idle; last rx_rvalid -> bram_we +1 -> op_done +2.
// Backpressure: rx_ralmostfull is held high outside RECEIVE; dma_start waits while dma_active is set.
module glm_load #(
    parameter int NUM_CHANNELS = 2,
    parameter int CL_ADDR_W    = 42,
    parameter int BRAM_ADDR_W  = 10,
    parameter int DATA_W       = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_start,
    output logic                    op_done,
    input  logic [6:0][31:0]        regs,
    input  logic [CL_ADDR_W-1:0]    in_addr,
    input  logic [CL_ADDR_W-1:0]    out_addr,
    output logic                    dma_start,
    output logic [CL_ADDR_W-1:0]    dma_addr,
    output logic [31:0]             dma_length,
    input  logic                    dma_active,
    input  logic                    rx_rvalid,
    input  logic [DATA_W-1:0]       rx_rdata,
    output logic                    rx_ralmostfull,
    output logic [NUM_CHANNELS-1:0] bram_we,
    output logic [BRAM_ADDR_W-1:0]  bram_waddr,
    output logic [DATA_W-1:0]       bram_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPROCESS,
        S_REQUEST,
        S_RECEIVE,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_pp_idx;
    logic [31:0]             r_off0;
    logic [31:0]             r_off1;
    logic [31:0]             r_off2;
    logic [CL_ADDR_W-1:0]    r_addr;
    logic [31:0]             r_len;
    logic [31:0]             r_count;
    logic [3:0]              r_ch;
    logic [BRAM_ADDR_W-1:0]  r_bram_base;
    logic                    r_op_done;
    logic                    r_dma_start;
    logic                    r_almostfull;
    logic [NUM_CHANNELS-1:0] r_bram_we;
    logic [BRAM_ADDR_W-1:0]  r_bram_waddr;
    logic [DATA_W-1:0]       r_bram_wdata;

    logic [CL_ADDR_W-1:0]    w_base_sel;
    logic [CL_ADDR_W-1:0]    w_start_addr;
    logic [31:0]             w_off_sel;
    logic [31:0]             w_len_m1;
    logic [NUM_CHANNELS-1:0] w_ch_we;
    logic                    w_unused;

    assign w_base_sel   = regs[3][31] ? out_addr : in_addr;
    assign w_start_addr = w_base_sel + CL_ADDR_W'(regs[3][30:0]);
    assign w_len_m1     = r_len - 32'd1;
    assign w_unused     = ^{regs[5][31:4], regs[6][31:BRAM_ADDR_W]};

    always_comb begin
        w_off_sel = r_off2;
        case (r_pp_idx)
            2'd0:    w_off_sel = r_off0;
            2'd1:    w_off_sel = r_off1;
            default: w_off_sel = r_off2;
        endcase
    end

    // Out-of-range channels decode to all-zero enables: lines are still consumed.
    always_comb begin
        w_ch_we = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_ch_we[i] = ({28'd0, r_ch} == 32'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pp_idx     <= 2'd0;
            r_off0       <= '0;
            r_off1       <= '0;
            r_off2       <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_ch         <= '0;
            r_bram_base  <= '0;
            r_op_done    <= 1'b0;
            r_dma_start  <= 1'b0;
            r_almostfull <= 1'b0;
            r_bram_we    <= '0;
            r_bram_waddr <= '0;
            r_bram_wdata <= '0;
        end else begin
            r_op_done    <= 1'b0;
            r_dma_start  <= 1'b0;
            r_bram_we    <= '0;
            r_almostfull <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        r_off0      <= regs[0];
                        r_off1      <= regs[1];
                        r_off2      <= regs[2];
                        r_addr      <= w_start_addr;
                        r_len       <= regs[4];
                        r_ch        <= regs[5][3:0];
                        r_bram_base <= regs[6][BRAM_ADDR_W-1:0];
                        r_pp_idx    <= 2'd0;
                        r_count     <= '0;
                        r_state     <= (regs[4] == 32'd0) ? S_DONE : S_PREPROCESS;
                    end
                end
                S_PREPROCESS: begin
                    r_addr   <= r_addr + CL_ADDR_W'(w_off_sel);
                    r_pp_idx <= r_pp_idx + 2'd1;
                    if (r_pp_idx == 2'd2) begin
                        r_state <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    if (!dma_active) begin
                        r_dma_start  <= 1'b1;
                        r_almostfull <= 1'b0;
                        r_state      <= S_RECEIVE;
                    end
                end
                S_RECEIVE: begin
                    r_almostfull <= 1'b0;
                    if (rx_rvalid) begin
                        r_bram_we    <= w_ch_we;
                        r_bram_waddr <= r_bram_base + r_count[BRAM_ADDR_W-1:0];
                        r_bram_wdata <= rx_rdata;
                        r_count      <= r_count + 32'd1;
                        if (r_count == w_len_m1) begin
                            r_almostfull <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_op_done <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_done        = r_op_done;
    assign dma_start      = r_dma_start;
    assign dma_addr       = r_addr;
    assign dma_length     = r_len;
    assign rx_ralmostfull = r_almostfull;
    assign bram_we        = r_bram_we;
    assign bram_waddr     = r_bram_waddr;
    assign bram_wdata     = r_bram_wdata;

endmodule

// File: tb/tb_glm_load.sv
// Directed bench for glm_load: each scenario task drives an op and checks captured events inline.
module tb_glm_load;
    localparam int NCH = 2;
    localparam int AW  = 42;
    localparam int BW  = 10;
    localparam int DW  = 512;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            op_start = 1'b0;
    logic            op_done;
    logic [6:0][31:0] regs = '0;
    logic [AW-1:0]   in_addr = '0;
    logic [AW-1:0]   out_addr = '0;
    logic            dma_start;
    logic [AW-1:0]   dma_addr;
    logic [31:0]     dma_length;
    logic            dma_active = 1'b0;
    logic            rx_rvalid = 1'b0;
    logic [DW-1:0]   rx_rdata = '0;
    logic            rx_ralmostfull;
    logic [NCH-1:0]  bram_we;
    logic [BW-1:0]   bram_waddr;
    logic [DW-1:0]   bram_wdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [NCH-1:0] q_we[$];
    logic [BW-1:0]  q_addr[$];
    logic [DW-1:0]  q_dat[$];
    int             q_cyc[$];
    int             dma_cnt = 0;
    logic [AW-1:0]  dma_a = '0;
    logic [31:0]    dma_l = '0;
    int             dma_c = 0;
    int             done_cnt = 0;
    int             done_c = 0;

    glm_load #(.NUM_CHANNELS(NCH), .CL_ADDR_W(AW), .BRAM_ADDR_W(BW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done), .regs(regs),
        .in_addr(in_addr), .out_addr(out_addr), .dma_start(dma_start), .dma_addr(dma_addr),
        .dma_length(dma_length), .dma_active(dma_active), .rx_rvalid(rx_rvalid),
        .rx_rdata(rx_rdata), .rx_ralmostfull(rx_ralmostfull), .bram_we(bram_we),
        .bram_waddr(bram_waddr), .bram_wdata(bram_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we != '0) begin
            q_we.push_back(bram_we);
            q_addr.push_back(bram_waddr);
            q_dat.push_back(bram_wdata);
            q_cyc.push_back(cyc);
        end
        if (dma_start) begin
            dma_cnt++;
            dma_a = dma_addr;
            dma_l = dma_length;
            dma_c = cyc;
        end
        if (op_done) begin
            done_cnt++;
            done_c = cyc;
        end
    end

    task automatic clear_mon();
        q_we.delete(); q_addr.delete(); q_dat.delete(); q_cyc.delete();
        dma_cnt = 0; done_cnt = 0; dma_c = 0; done_c = 0;
    endtask

    // Programs the registers, pulses op_start, waits for the DMA request, then returns lines.
    task automatic run_op(input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                          input logic [31:0] r3, input logic [31:0] r4, input logic [31:0] r5,
                          input logic [31:0] r6, input logic [31:0] seed, input int kill_after,
                          output bit got_dma, output int start_c, output int last_vld);
        @(negedge clk);
        regs[0] = o0; regs[1] = o1; regs[2] = o2; regs[3] = r3;
        regs[4] = r4; regs[5] = r5; regs[6] = r6;
        op_start = 1'b1;
        start_c = cyc;
        @(negedge clk);
        op_start = 1'b0;
        got_dma = 1'b0;
        last_vld = 0;
        if (r4 != 32'd0) begin
            for (int i = 0; i < 60 && !got_dma; i++) begin
                if (dma_cnt > 0) got_dma = 1'b1;
                else @(negedge clk);
            end
            if (got_dma) begin
                for (int k = 0; k < int'(r4); k++) begin
                    if (k == kill_after) break;
                    if (k == 1) @(negedge clk);
                    rx_rvalid = 1'b1;
                    rx_rdata = {16{seed + 32'(k)}};
                    last_vld = cyc;
                    @(negedge clk);
                    rx_rvalid = 1'b0;
                end
            end
        end
        rx_rvalid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (op_done !== 1'b0) begin bad++; $display("FAIL rst_op_done got=%b want=0", op_done); end
        total++; if (dma_start !== 1'b0) begin bad++; $display("FAIL rst_dma_start got=%b want=0", dma_start); end
        total++; if (bram_we !== 2'b00) begin bad++; $display("FAIL rst_bram_we got=%b want=00", bram_we); end
        total++; if (rx_ralmostfull !== 1'b0) begin bad++; $display("FAIL rst_almostfull got=%b want=0", rx_ralmostfull); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (rx_ralmostfull !== 1'b1) begin bad++; $display("FAIL idle_almostfull got=%b want=1", rx_ralmostfull); end
    endtask

    task automatic test_main();
        bit got; int s, lv;
        logic [DW-1:0] exp_d;
        clear_mon();
        in_addr = 42'h1000; out_addr = 42'h2000;
        fork
            run_op(32'd1, 32'd2, 32'd3, 32'h5, 32'd4, 32'd0, 32'd0, 32'hA000_0000, 99, got, s, lv);
            begin
                repeat (8) @(negedge clk);
                op_start = 1'b1;
                @(negedge clk);
                op_start = 1'b0;
            end
        join
        total++; if (!got) begin bad++; $display("FAIL main_dma_timeout got=0 want=1"); end
        total++; if (dma_a !== 42'h100B) begin bad++; $display("FAIL main_dma_addr got=%h want=100b", dma_a); end
        total++; if (dma_l !== 32'd4) begin bad++; $display("FAIL main_dma_len got=%0d want=4", dma_l); end
        total++; if (dma_cnt != 1) begin bad++; $display("FAIL main_dma_cnt got=%0d want=1", dma_cnt); end
        total++; if (q_addr.size() != 4) begin bad++; $display("FAIL main_wr_cnt got=%0d want=4", q_addr.size()); end
        for (int k = 0; k < 4 && k < q_addr.size(); k++) begin
            exp_d = {16{32'hA000_0000 + 32'(k)}};
            total++; if (q_we[k] !== 2'b01) begin bad++; $display("FAIL main_we[%0d] got=%b want=01", k, q_we[k]); end
            total++; if (q_addr[k] !== BW'(k)) begin bad++; $display("FAIL main_addr[%0d] got=%h want=%h", k, q_addr[k], k); end
            total++; if (q_dat[k] !== exp_d) begin bad++; $display("FAIL main_data[%0d] got=%h want=%h", k, q_dat[k][31:0], exp_d[31:0]); end
        end
        if (q_cyc.size() > 0) begin
            total++; if (q_cyc[q_cyc.size()-1] != lv + 1) begin bad++; $display("FAIL main_we_lat got=%0d want=%0d", q_cyc[q_cyc.size()-1], lv + 1); end
        end
        total++; if (done_c != lv + 2) begin bad++; $display("FAIL main_done_lat got=%0d want=%0d", done_c, lv + 2); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL main_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_len0();
        bit got; int s, lv;
        clear_mon();
        run_op(32'd1, 32'd2, 32'd3, 32'h0, 32'd0, 32'd0, 32'd0, 32'h0, 99, got, s, lv);
        total++; if (dma_cnt != 0) begin bad++; $display("FAIL len0_dma got=%0d want=0", dma_cnt); end
        total++; if (q_addr.size() != 0) begin bad++; $display("FAIL len0_writes got=%0d want=0", q_addr.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL len0_done_cnt got=%0d want=1", done_cnt); end
        total++; if (done_c - s != 2) begin bad++; $display("FAIL len0_done_lat got=%0d want=2", done_c - s); end
    endtask

    task automatic test_out_base();
        bit got; int s, lv;
        clear_mon();
        run_op(32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'd2, 32'd1, 32'h3FE, 32'hB000_0000, 99, got, s, lv);
        total++; if (dma_a !== 42'h2000) begin bad++; $display("FAIL outb_dma_addr got=%h want=2000", dma_a); end
        total++; if (q_addr.size() != 2) begin bad++; $display("FAIL outb_wr_cnt got=%0d want=2", q_addr.size()); end
        if (q_addr.size() == 2) begin
            total++; if (q_addr[0] !== 10'h3FE || q_addr[1] !== 10'h3FF) begin bad++; $display("FAIL outb_addr got=%h,%h want=3fe,3ff", q_addr[0], q_addr[1]); end
            total++; if (q_we[0] !== 2'b10 || q_we[1] !== 2'b10) begin bad++; $display("FAIL outb_we got=%b,%b want=10,10", q_we[0], q_we[1]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL outb_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit got; int s, lv;
        clear_mon();
        run_op(32'd7, 32'd0, 32'h10, 32'h0, 32'd3, 32'd0, 32'h3FF, 32'hC000_0000, 99, got, s, lv);
        total++; if (dma_a !== 42'h1017) begin bad++; $display("FAIL wrap_dma_addr got=%h want=1017", dma_a); end
        total++; if (q_addr.size() != 3) begin bad++; $display("FAIL wrap_wr_cnt got=%0d want=3", q_addr.size()); end
        if (q_addr.size() == 3) begin
            total++; if (q_addr[0] !== 10'h3FF || q_addr[1] !== 10'h000 || q_addr[2] !== 10'h001) begin
                bad++; $display("FAIL wrap_addr got=%h,%h,%h want=3ff,000,001", q_addr[0], q_addr[1], q_addr[2]); end
            total++; if (q_dat[2][31:0] !== 32'hC000_0002) begin bad++; $display("FAIL wrap_data got=%h want=c0000002", q_dat[2][31:0]); end
        end
    endtask

    task automatic test_dma_wait();
        bit got; int s, lv; int drop_c;
        clear_mon();
        dma_active = 1'b1;
        drop_c = 0;
        fork
            run_op(32'd0, 32'd0, 32'd0, 32'h0, 32'd1, 32'd0, 32'd0, 32'hD000_0000, 99, got, s, lv);
            begin
                @(negedge clk);
                repeat (9) @(negedge clk);
                dma_active = 1'b0;
                drop_c = cyc;
            end
        join
        total++; if (dma_cnt != 1) begin bad++; $display("FAIL dmaw_cnt got=%0d want=1", dma_cnt); end
        total++; if (dma_c != drop_c + 1) begin bad++; $display("FAIL dmaw_start_cyc got=%0d want=%0d", dma_c, drop_c + 1); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL dmaw_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid_op();
        bit got; int s, lv;
        clear_mon();
        run_op(32'd0, 32'd0, 32'd0, 32'h0, 32'd4, 32'd0, 32'd0, 32'hE000_0000, 2, got, s, lv);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rx_rvalid = 1'b1; rx_rdata = {16{32'hDEAD_BEEF}};
        repeat (2) @(negedge clk);
        rx_rvalid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (q_addr.size() != 2) begin bad++; $display("FAIL rmid_writes got=%0d want=2", q_addr.size()); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rmid_done got=%0d want=0", done_cnt); end
        total++; if (rx_ralmostfull !== 1'b1) begin bad++; $display("FAIL rmid_almostfull got=%b want=1", rx_ralmostfull); end
        clear_mon();
        run_op(32'd0, 32'd0, 32'd0, 32'h0, 32'd2, 32'd0, 32'h10, 32'hF000_0000, 99, got, s, lv);
        total++; if (q_addr.size() != 2) begin bad++; $display("FAIL rnext_writes got=%0d want=2", q_addr.size()); end
        if (q_addr.size() == 2) begin
            total++; if (q_addr[0] !== 10'h010 || q_addr[1] !== 10'h011) begin bad++; $display("FAIL rnext_addr got=%h,%h want=010,011", q_addr[0], q_addr[1]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rnext_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_bad_channel();
        bit got; int s, lv;
        clear_mon();
        run_op(32'd0, 32'd0, 32'd0, 32'h0, 32'd2, 32'd7, 32'd0, 32'h1234_0000, 99, got, s, lv);
        total++; if (!got) begin bad++; $display("FAIL badch_dma got=0 want=1"); end
        total++; if (q_addr.size() != 0) begin bad++; $display("FAIL badch_writes got=%0d want=0", q_addr.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL badch_done got=%0d want=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_main();
        test_len0();
        test_out_base();
        test_wrap();
        test_dma_wait();
        test_reset_mid_op();
        test_bad_channel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule
